// File: rtl/uart_pkg.sv
// UART transmitter shared definitions: FSM states, register map, STATUS layout.
// UART_TX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  localparam logic [31:0] OFF_TXDATA = 32'd0;
  localparam logic [31:0] OFF_STATUS = 32'd4;

  localparam int ST_BUSY   = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_EMPTY  = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_CNT_LO = 4;
  localparam int ST_CNT_HI = 8;

  function automatic logic [31:0] status_word(
    input logic       busy,
    input logic       full,
    input logic       empty,
    input logic       ovf,
    input logic [4:0] cnt
  );
    logic [31:0] w;
    w = '0;
    w[ST_BUSY]  = busy;
    w[ST_FULL]  = full;
    w[ST_EMPTY] = empty;
    w[ST_OVF]   = ovf;
    w[ST_CNT_HI:ST_CNT_LO] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Transmit byte FIFO: power-of-two depth, wrapping pointers, occupancy count.
// Caller guarantees no pop when empty and no push when full unless popping.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [4:0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q, cnt_d;

  // occupancy moves only when exactly one of push/pop happens
  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !pop_i) cnt_d = cnt_q + 1'b1;
    else if (!push_i && pop_i) cnt_d = cnt_q - 1'b1;
  end

  // pointers and count, cleared by reset so contents are discarded
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + 1'b1;
      if (pop_i) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // storage array needs no reset
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wp_q] <= din_i;
  end

  assign dout_o  = mem_q[rp_q];
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = 5'(cnt_q);

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: TXDATA push port, STATUS read, serial FSM.
// Define UART_TX_PARITY_EN to append an even-parity bit to every frame.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        sel,
  output logic        tx
);
  localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [7:0]  sh_q;
  logic [2:0]  bit_q;
  logic        tx_q;
  logic        ovf_q, ovf_d;
`ifdef UART_TX_PARITY_EN
  logic        par_q;
`endif

  logic        hit_tx, hit_st;
  logic        wr_tx, wr_st;
  logic        bit_end, pop, push;
  logic        f_full, f_empty;
  logic [7:0]  f_head;
  logic [4:0]  f_cnt;
  logic        unused_wd;

  assign hit_tx  = DataAdr == BASE_ADDR + OFF_TXDATA;
  assign hit_st  = DataAdr == BASE_ADDR + OFF_STATUS;
  assign sel     = hit_tx | hit_st;
  assign wr_tx   = MemWrite & hit_tx;
  assign wr_st   = MemWrite & hit_st;
  assign bit_end = cnt_q == '0;
  assign unused_wd = ^WriteData[31:8];

  // a new frame starts from IDLE or straight out of a finished STOP
  assign pop = !f_empty &&
               ((state_q == S_IDLE) ||
                (state_q == S_STOP && bit_end));

  // a full FIFO still accepts a byte on the edge that frees a slot
  assign push = wr_tx & (!f_full | pop);

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (WriteData[7:0]),
    .dout_o  (f_head),
    .full_o  (f_full),
    .empty_o (f_empty),
    .count_o (f_cnt)
  );

  // sticky overflow: set on a dropped byte, cleared by any STATUS write
  always_comb begin
    ovf_d = ovf_q;
    if (wr_tx && f_full && !pop) ovf_d = 1'b1;
    if (wr_st) ovf_d = 1'b0;
  end

  // overflow flag register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end

  // serial FSM with bit timer, shift register and registered tx
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q <= S_START;
            sh_q    <= f_head;
            tx_q    <= 1'b0;
            cnt_q   <= RELOAD;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^f_head;
`endif
          end
        end
        S_START: begin
          if (bit_end) begin
            state_q <= S_DATA;
            tx_q    <= sh_q[0];
            bit_q   <= '0;
            cnt_q   <= RELOAD;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_DATA: begin
          if (!bit_end) begin
            cnt_q <= cnt_q - 16'd1;
          end else if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_q <= S_PARITY;
            tx_q    <= par_q;
`else
            state_q <= S_STOP;
            tx_q    <= 1'b1;
`endif
            cnt_q   <= RELOAD;
          end else begin
            sh_q  <= sh_q >> 1;
            tx_q  <= sh_q[1];
            bit_q <= bit_q + 3'd1;
            cnt_q <= RELOAD;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            state_q <= S_STOP;
            tx_q    <= 1'b1;
            cnt_q   <= RELOAD;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (!bit_end) begin
            cnt_q <= cnt_q - 16'd1;
          end else if (pop) begin
            state_q <= S_START;
            sh_q    <= f_head;
            tx_q    <= 1'b0;
            cnt_q   <= RELOAD;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^f_head;
`endif
          end else begin
            state_q <= S_IDLE;
            tx_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx = tx_q;

  assign ReadData = hit_st ?
    status_word(state_q != S_IDLE, f_full,
                f_empty, ovf_q, f_cnt) :
    32'd0;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with a frame-level reference model.
// Honours UART_TX_PARITY_EN for frame length and parity checks.
module tb_uart_tx_mmio;
  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = BASE + 32'd4;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        sel;
  logic        tx;

  uart_tx_mmio #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .sel       (sel),
    .tx        (tx)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // frame-level model: byte queue, active frame byte, cycle within frame
  int         cyc = 0;
  logic [7:0] mq[$];
  bit         m_act = 0;
  int         m_t = 0;
  logic [7:0] m_cur = '0;
  bit         m_ovf = 0;
  bit         m_popping;
  bit         m_accept;

  function automatic logic m_tx();
    int bi;
    if (!m_act) return 1'b1;
    bi = m_t / CPB;
    if (bi == 0) return 1'b0;
    if (bi <= 8) return m_cur[bi-1];
`ifdef UART_TX_PARITY_EN
    if (bi == 9) return ^m_cur;
`endif
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[0] = m_act;
    s[1] = mq.size() == DEPTH;
    s[2] = mq.size() == 0;
    s[3] = m_ovf;
    s[8:4] = 5'(mq.size());
    return s;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      mq.delete();
      m_act = 0;
      m_t = 0;
      m_ovf = 0;
    end else begin
      m_popping = mq.size() != 0 && (!m_act || m_t == FL - 1);
      m_accept = mq.size() < DEPTH || m_popping;
      if (m_popping) begin
        m_cur = mq.pop_front();
        m_act = 1;
        m_t = 0;
      end else if (m_act) begin
        if (m_t == FL - 1) m_act = 0;
        else m_t++;
      end
      if (MemWrite && DataAdr == BASE) begin
        if (m_accept) mq.push_back(WriteData[7:0]);
        else m_ovf = 1;
      end
      if (MemWrite && DataAdr == BASE + 32'd4) m_ovf = 0;
    end
    #4;
    if (!reset) begin
      check("cmp_tx", 32'(tx), 32'(m_tx()));
      check("cmp_sel", 32'(sel),
            32'(DataAdr == BASE || DataAdr == BASE + 32'd4));
      check("cmp_rd", ReadData,
            DataAdr == BASE + 32'd4 ? m_status() : 32'd0);
    end
  end

  // independent line receiver, sampling mid-bit
  bit         rx_en = 0;
  logic [7:0] rxq[$];
  logic [7:0] rb;

  initial forever begin
    @(posedge clk);
    #1;
    if (rx_en && tx == 1'b0) begin
      repeat (CPB / 2) @(posedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(posedge clk);
        #1;
        rb[k] = tx;
      end
`ifdef UART_TX_PARITY_EN
      repeat (CPB) @(posedge clk);
      #1;
      check("rx_parity", 32'(tx), 32'(^rb));
`endif
      repeat (CPB) @(posedge clk);
      #1;
      check("rx_stop", 32'(tx), 32'd1);
      rxq.push_back(rb);
    end
  end

  task automatic write_at(int t, logic [31:0] a, logic [31:0] d);
    while (cyc < t - 1) @(negedge clk);
    MemWrite = 1'b1;
    DataAdr = a;
    WriteData = d;
    @(negedge clk);
    MemWrite = 1'b0;
    DataAdr = BASE + 32'd4;
    WriteData = '0;
  endtask

  task automatic wait_edge(int t);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < t);
  endtask

  task automatic rd_status(string nm, logic [31:0] exp);
    DataAdr = BASE + 32'd4;
    #1;
    check(nm, ReadData, exp);
  endtask

  logic [10:0] a5f;
  logic [7:0]  exp_b [6];
  int          n, s, c;

  initial begin
`ifdef UART_TX_PARITY_EN
    a5f = 11'b10_1010_0101_0;
`else
    a5f = 11'b01_1010_0101_0;
`endif
    exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h07};

    #1 reset = 1'b1;
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_sel", 32'(sel), 32'd1);
    rd_status("rst_status", 32'h4);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // single byte A5: exact waveform and busy timing
    n = cyc + 1;
    write_at(n, BASE, 32'h0000_00A5);
    for (int j = 0; j < FL; j++) begin
      wait_edge(n + 1 + j);
      check("a5_bit", 32'(tx), 32'(a5f[j / CPB]));
    end
    rd_status("a5_busy_end", 32'h5);
    wait_edge(n + FL + 1);
    rd_status("a5_idle", 32'h4);

    // burst of five, overflow, clear, push on a full pop edge
    rx_en = 1;
    @(negedge clk);
    s = cyc;
    for (int i = 1; i <= 5; i++) begin
      MemWrite = 1'b1;
      DataAdr = BASE;
      WriteData = 32'hABCD_EF00 | 32'(i);
      @(negedge clk);
    end
    MemWrite = 1'b0;
    DataAdr = BASE + 32'd4;
    rd_status("burst_full", 32'h43);
    write_at(s + 7, BASE, 32'h0000_0006);
    rd_status("ovf_set", 32'h4B);
    write_at(s + 9, BASE + 32'd4, 32'hFFFF_FFFF);
    rd_status("ovf_clr", 32'h43);
    write_at(s + 2 + FL, BASE, 32'h0000_0007);
    rd_status("push_on_pop", 32'h43);
    while (cyc < s + 2 + 6 * FL + 2) @(negedge clk);
    rd_status("burst_idle", 32'h4);
    check("rx_count", 32'(rxq.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < rxq.size()) check("rx_byte", 32'(rxq[i]), 32'(exp_b[i]));
    end
    rx_en = 0;
    rxq.delete();

    // write during STOP: next START with no idle cycle
    @(negedge clk);
    n = cyc + 1;
    write_at(n, BASE, 32'h0000_003C);
    write_at(n + 2 + (NB - 1) * CPB, BASE, 32'h0000_00C3);
    wait_edge(n + FL);
    check("stop_tail", 32'(tx), 32'd1);
    wait_edge(n + FL + 1);
    check("b2b_start", 32'(tx), 32'd0);
    rd_status("b2b_busy", 32'h5);
    while (cyc < n + 2 + 2 * FL) @(negedge clk);
    rd_status("b2b_idle", 32'h4);

    // unmapped addresses
    @(negedge clk);
    MemWrite = 1'b1;
    DataAdr = BASE + 32'd8;
    WriteData = 32'h0000_0055;
    @(negedge clk);
    MemWrite = 1'b0;
    DataAdr = BASE + 32'd12;
    #1;
    check("adr12_sel", 32'(sel), 32'd0);
    check("adr12_rd", ReadData, 32'd0);
    DataAdr = BASE;
    #1;
    check("adr0_sel", 32'(sel), 32'd1);
    check("adr0_rd", ReadData, 32'd0);
    rd_status("adr8_nopush", 32'h4);

`ifdef UART_TX_PARITY_EN
    // parity bit values
    @(negedge clk);
    n = cyc + 1;
    write_at(n, BASE, 32'h0000_0007);
    wait_edge(n + 1 + 9 * CPB);
    check("par_07", 32'(tx), 32'd1);
    while (cyc < n + FL + 2) @(negedge clk);
    n = cyc + 1;
    write_at(n, BASE, 32'h0000_0003);
    wait_edge(n + 1 + 9 * CPB);
    check("par_03", 32'(tx), 32'd0);
    while (cyc < n + FL + 2) @(negedge clk);
    rd_status("par_idle", 32'h4);
`endif

    // reset in the middle of a data bit
    @(negedge clk);
    n = cyc + 1;
    write_at(n, BASE, 32'h0000_0000);
    wait_edge(n + 2 + 2 * CPB);
    check("pre_rst_tx", 32'(tx), 32'd0);
    #1 reset = 1'b1;
    #1;
    check("rst_tx_async", 32'(tx), 32'd1);
    rd_status("rst_mid_status", 32'h4);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    c = cyc;
    for (int j = 0; j < FL; j++) begin
      wait_edge(c + 1 + j);
      check("post_rst_tx", 32'(tx), 32'd1);
    end
    rd_status("post_rst_status", 32'h4);

    // normal operation resumes after reset
    @(negedge clk);
    n = cyc + 1;
    write_at(n, BASE, 32'h0000_005A);
    wait_edge(n + 1);
    check("resume_start", 32'(tx), 32'd0);
    while (cyc < n + FL + 2) @(negedge clk);
    rd_status("final_idle", 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
